// File: rtl/cpu_trace_capture_pkg.sv
// Shared trace-entry definitions: event type codes, field offsets and entry width.
// Entry width grows to 64 bits when TRACE_TIMESTAMP_EN is defined.
package cpu_trace_capture_pkg;

  localparam logic [1:0] TR_TYPE_REG  = 2'b01;
  localparam logic [1:0] TR_TYPE_MEM  = 2'b10;
  localparam logic [1:0] TR_TYPE_BOTH = 2'b11;

  localparam int TR_DATA_LSB = 0;
  localparam int TR_ADDR_LSB = 32;
  localparam int TR_PC_LSB   = 38;
  localparam int TR_TYPE_LSB = 46;
  localparam int TR_BASE_W   = 48;

`ifdef TRACE_TIMESTAMP_EN
  localparam int TR_TS_LSB  = 48;
  localparam int TR_ENTRY_W = 64;
`else
  localparam int TR_ENTRY_W = 48;
`endif

  // Base entry layout: {type, pc, addr, data}, timestamp (if any) goes above it.
  function automatic logic [TR_BASE_W-1:0] pack_entry(
    input logic [1:0]  ev_type,
    input logic [7:0]  ev_pc,
    input logic [5:0]  ev_addr,
    input logic [31:0] ev_data
  );
    return {ev_type, ev_pc, ev_addr, ev_data};
  endfunction

endpackage

// File: rtl/cpu_trace_capture_fifo.sv
// trace_fifo: single-clock show-ahead FIFO; head entry is read straight from the array.
// Occupancy is tracked in a count register; pointers carry one extra wrap bit.
module trace_fifo #(
  parameter int WIDTH  = 48,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_W:0]  wr_ptr_r;
  logic [ADDR_W:0]  rd_ptr_r;
  logic [ADDR_W:0]  count_r;
  logic             rd_ok_s;
  logic             wr_ok_s;

  assign full    = (count_r == DEPTH_C);
  assign empty   = (count_r == ZERO_C);
  assign count   = count_r;
  assign dout    = mem_r[rd_ptr_r[ADDR_W-1:0]];
  // A push into a full FIFO is still accepted when a pop frees the head slot this cycle.
  assign rd_ok_s = pop & ~empty;
  assign wr_ok_s = push & (~full | rd_ok_s);

  // Storage array; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s & ~clr) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= din;
    end
  end

  // Pointer and occupancy registers; clr overrides any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= ZERO_C;
      rd_ptr_r <= ZERO_C;
      count_r  <= ZERO_C;
    end else if (clr) begin
      wr_ptr_r <= ZERO_C;
      rd_ptr_r <= ZERO_C;
      count_r  <= ZERO_C;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: snoops CPU register/memory write strobes, packs trace entries into a FIFO
// and streams them out over valid/ready. Optional macro TRACE_TIMESTAMP_EN adds a 16-bit timestamp.
module cpu_trace_capture
  import cpu_trace_capture_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DROP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_en,
  input  logic                  clr,
  input  logic [7:0]            pc,
  input  logic                  r3_wr,
  input  logic [4:0]            r3_addr,
  input  logic [31:0]           r3_din,
  input  logic                  wea,
  input  logic [5:0]            addra,
  input  logic [31:0]           mem_din,
  output logic                  tr_valid,
  input  logic                  tr_ready,
  output logic [TR_ENTRY_W-1:0] tr_data,
  output logic                  tr_overflow,
  output logic                  tr_collide,
  output logic [DROP_W-1:0]     tr_drops
);

  logic                  event_s;
  logic                  pop_s;
  logic                  drop_s;
  logic                  collide_s;
  logic [1:0]            ev_type_s;
  logic [5:0]            ev_addr_s;
  logic [31:0]           ev_data_s;
  logic [TR_ENTRY_W-1:0] entry_s;
  logic [TR_ENTRY_W-1:0] fifo_dout_s;
  logic [ADDR_W:0]       fifo_count_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  overflow_r;
  logic                  collide_r;
  logic [DROP_W-1:0]     drops_r;

  assign event_s   = cap_en & (r3_wr | wea);
  assign collide_s = cap_en & r3_wr & wea;
  assign pop_s     = tr_ready & ~fifo_empty_s;
  assign drop_s    = event_s & fifo_full_s & ~pop_s;

  // Event encoding; on collision the register write wins and memory fields are discarded.
  always_comb begin
    ev_type_s = 2'b00;
    ev_addr_s = 6'd0;
    ev_data_s = 32'd0;
    case ({r3_wr, wea})
      2'b10: begin
        ev_type_s = TR_TYPE_REG;
        ev_addr_s = {1'b0, r3_addr};
        ev_data_s = r3_din;
      end
      2'b01: begin
        ev_type_s = TR_TYPE_MEM;
        ev_addr_s = addra;
        ev_data_s = mem_din;
      end
      2'b11: begin
        ev_type_s = TR_TYPE_BOTH;
        ev_addr_s = {1'b0, r3_addr};
        ev_data_s = r3_din;
      end
      default: begin
        ev_type_s = 2'b00;
        ev_addr_s = 6'd0;
        ev_data_s = 32'd0;
      end
    endcase
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_r;

  // Free-running cycle counter sampled into each entry at its event edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r <= 16'd0;
    end else if (clr) begin
      ts_r <= 16'd0;
    end else begin
      ts_r <= ts_r + 16'd1;
    end
  end

  assign entry_s = {ts_r, pack_entry(ev_type_s, pc, ev_addr_s, ev_data_s)};
`else
  assign entry_s = pack_entry(ev_type_s, pc, ev_addr_s, ev_data_s);
`endif

  trace_fifo #(
    .WIDTH  (TR_ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (event_s),
    .pop   (tr_ready),
    .din   (entry_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Sticky status flags and saturating drop counter; only clr or reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      collide_r  <= 1'b0;
      drops_r    <= {DROP_W{1'b0}};
    end else if (clr) begin
      overflow_r <= 1'b0;
      collide_r  <= 1'b0;
      drops_r    <= {DROP_W{1'b0}};
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drops_r != {DROP_W{1'b1}}) begin
          drops_r <= drops_r + {{(DROP_W-1){1'b0}}, 1'b1};
        end
      end
      if (collide_s) begin
        collide_r <= 1'b1;
      end
    end
  end

  assign tr_valid    = (fifo_count_s != {(ADDR_W+1){1'b0}});
  assign tr_data     = fifo_empty_s ? {TR_ENTRY_W{1'b0}} : fifo_dout_s;
  assign tr_overflow = overflow_r;
  assign tr_collide  = collide_r;
  assign tr_drops    = drops_r;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Directed self-checking bench for cpu_trace_capture (DEPTH=16, DROP_W=8).
module tb_cpu_trace_capture;

`ifdef TRACE_TIMESTAMP_EN
  localparam int TW = 64;
`else
  localparam int TW = 48;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cap_en = 1'b1;
  logic          clr = 1'b0;
  logic [7:0]    pc = 8'h00;
  logic          r3_wr = 1'b0;
  logic [4:0]    r3_addr = 5'd0;
  logic [31:0]   r3_din = 32'd0;
  logic          wea = 1'b0;
  logic [5:0]    addra = 6'd0;
  logic [31:0]   mem_din = 32'd0;
  logic          tr_valid;
  logic          tr_ready = 1'b0;
  logic [TW-1:0] tr_data;
  logic          tr_overflow;
  logic          tr_collide;
  logic [7:0]    tr_drops;

  int checks = 0;
  int fails  = 0;
  logic [15:0] tb_ts;

  cpu_trace_capture #(.DEPTH(16), .ADDR_W(4), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .clr(clr), .pc(pc),
    .r3_wr(r3_wr), .r3_addr(r3_addr), .r3_din(r3_din),
    .wea(wea), .addra(addra), .mem_din(mem_din),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data),
    .tr_overflow(tr_overflow), .tr_collide(tr_collide), .tr_drops(tr_drops)
  );

  always #5 clk = ~clk;

  // Reference cycle counter for timestamp expectations.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= 16'd0;
    else if (clr) tb_ts <= 16'd0;
    else tb_ts <= tb_ts + 16'd1;
  end

  task automatic push_reg(input logic [7:0] p, input logic [4:0] a, input logic [31:0] d);
    pc = p; r3_addr = a; r3_din = d; r3_wr = 1'b1;
    @(negedge clk);
    r3_wr = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", tr_valid); end
    checks++; if (tr_data[47:0] !== 48'd0) begin fails++; $display("FAIL reset_data: got %h expected 0", tr_data); end
    checks++; if (tr_overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", tr_overflow); end
    checks++; if (tr_collide !== 1'b0) begin fails++; $display("FAIL reset_col: got %b expected 0", tr_collide); end
    checks++; if (tr_drops !== 8'd0) begin fails++; $display("FAIL reset_drops: got %h expected 0", tr_drops); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_reg();
    logic [47:0] exp;
    exp = {2'b01, 8'h04, 6'h03, 32'h0000_0007};
    push_reg(8'h04, 5'd3, 32'h0000_0007);
    checks++; if (tr_valid !== 1'b1) begin fails++; $display("FAIL reg_valid: got %b expected 1", tr_valid); end
    checks++; if (tr_data[47:0] !== exp) begin fails++; $display("FAIL reg_data: got %h expected %h", tr_data[47:0], exp); end
`ifdef TRACE_TIMESTAMP_EN
    checks++; if (tr_data[63:48] !== tb_ts - 16'd1) begin fails++; $display("FAIL reg_ts: got %h expected %h", tr_data[63:48], tb_ts - 16'd1); end
`endif
    tr_ready = 1'b1;
    @(negedge clk);
    tr_ready = 1'b0;
    checks++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL reg_pop: got %b expected 0", tr_valid); end
  endtask

  task automatic test_mem_pop();
    logic [47:0] exp;
    exp = {2'b10, 8'h10, 6'h05, 32'hDEAD_BEEF};
    tr_ready = 1'b1;
    pc = 8'h10; addra = 6'd5; mem_din = 32'hDEAD_BEEF; wea = 1'b1;
    @(negedge clk);
    wea = 1'b0;
    checks++; if (tr_valid !== 1'b1) begin fails++; $display("FAIL mem_valid: got %b expected 1", tr_valid); end
    checks++; if (tr_data[47:0] !== exp) begin fails++; $display("FAIL mem_data: got %h expected %h", tr_data[47:0], exp); end
    @(negedge clk);
    checks++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL mem_pop: got %b expected 0", tr_valid); end
    tr_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [47:0] exp;
    for (int i = 0; i < 17; i++) push_reg(8'(i), 5'(i), 32'h100 + 32'(i));
    checks++; if (tr_overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b expected 1", tr_overflow); end
    checks++; if (tr_drops !== 8'd1) begin fails++; $display("FAIL ovf_drops: got %h expected 01", tr_drops); end
    tr_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = {2'b01, 8'(i), 6'(i), 32'h100 + 32'(i)};
      checks++; if (tr_valid !== 1'b1 || tr_data[47:0] !== exp) begin
        fails++; $display("FAIL ovf_drain[%0d]: got %b/%h expected 1/%h", i, tr_valid, tr_data[47:0], exp);
      end
      @(negedge clk);
    end
    checks++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty: got %b expected 0", tr_valid); end
    tr_ready = 1'b0;
    checks++; if (tr_overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", tr_overflow); end
  endtask

  task automatic test_full_pop();
    logic [47:0] exp;
    pulse_clr();
    checks++; if (tr_drops !== 8'd0 || tr_overflow !== 1'b0) begin fails++; $display("FAIL fp_clr: got %h/%b expected 00/0", tr_drops, tr_overflow); end
    for (int i = 0; i < 16; i++) push_reg(8'h20, 5'(i), 32'h200 + 32'(i));
    tr_ready = 1'b1;
    push_reg(8'hAA, 5'd31, 32'hCAFE_0000);
    checks++; if (tr_drops !== 8'd0 || tr_overflow !== 1'b0) begin fails++; $display("FAIL fp_nodrop: got %h/%b expected 00/0", tr_drops, tr_overflow); end
    for (int i = 1; i < 17; i++) begin
      exp = (i == 16) ? {2'b01, 8'hAA, 6'd31, 32'hCAFE_0000} : {2'b01, 8'h20, 6'(i), 32'h200 + 32'(i)};
      checks++; if (tr_valid !== 1'b1 || tr_data[47:0] !== exp) begin
        fails++; $display("FAIL fp_drain[%0d]: got %b/%h expected 1/%h", i, tr_valid, tr_data[47:0], exp);
      end
      @(negedge clk);
    end
    checks++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL fp_empty: got %b expected 0", tr_valid); end
    tr_ready = 1'b0;
  endtask

  task automatic test_collide_clr();
    logic [47:0] exp;
    exp = {2'b11, 8'h33, 6'h09, 32'h1234_5678};
    pc = 8'h33; r3_addr = 5'd9; r3_din = 32'h1234_5678; addra = 6'h2A; mem_din = 32'hFFFF_FFFF;
    r3_wr = 1'b1; wea = 1'b1;
    @(negedge clk);
    r3_wr = 1'b0; wea = 1'b0;
    checks++; if (tr_collide !== 1'b1) begin fails++; $display("FAIL col_flag: got %b expected 1", tr_collide); end
    checks++; if (tr_data[47:0] !== exp) begin fails++; $display("FAIL col_data: got %h expected %h", tr_data[47:0], exp); end
    clr = 1'b1; r3_wr = 1'b1;
    @(negedge clk);
    clr = 1'b0; r3_wr = 1'b0;
    checks++; if (tr_valid !== 1'b0 || tr_collide !== 1'b0 || tr_data[47:0] !== 48'd0) begin
      fails++; $display("FAIL col_clr: got %b/%b/%h expected 0/0/0", tr_valid, tr_collide, tr_data[47:0]);
    end
    push_reg(8'h44, 5'd1, 32'h0000_0042);
    exp = {2'b01, 8'h44, 6'd1, 32'h0000_0042};
    checks++; if (tr_data[47:0] !== exp) begin fails++; $display("FAIL col_head: got %h expected %h", tr_data[47:0], exp); end
    pulse_clr();
  endtask

  task automatic test_cap_en();
    cap_en = 1'b0;
    push_reg(8'h01, 5'd2, 32'h3);
    wea = 1'b1; r3_wr = 1'b1;
    @(negedge clk);
    wea = 1'b0; r3_wr = 1'b0;
    checks++; if (tr_valid !== 1'b0 || tr_collide !== 1'b0) begin fails++; $display("FAIL cap_off: got %b/%b expected 0/0", tr_valid, tr_collide); end
    cap_en = 1'b1;
  endtask

  task automatic test_drop_saturate();
    for (int i = 0; i < 276; i++) push_reg(8'h55, 5'd7, 32'(i));
    checks++; if (tr_drops !== 8'hFF || tr_overflow !== 1'b1) begin fails++; $display("FAIL sat_drops: got %h/%b expected ff/1", tr_drops, tr_overflow); end
    pulse_clr();
    checks++; if (tr_drops !== 8'h00 || tr_valid !== 1'b0) begin fails++; $display("FAIL sat_clr: got %h/%b expected 00/0", tr_drops, tr_valid); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) push_reg(8'h60, 5'(i), 32'(i));
    checks++; if (tr_valid !== 1'b1) begin fails++; $display("FAIL ar_pre: got %b expected 1", tr_valid); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tr_valid !== 1'b0 || tr_data[47:0] !== 48'd0) begin fails++; $display("FAIL ar_valid: got %b/%h expected 0/0", tr_valid, tr_data[47:0]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tr_valid !== 1'b0) begin fails++; $display("FAIL ar_post: got %b expected 0", tr_valid); end
  endtask

  initial begin
    test_reset();
    test_single_reg();
    test_mem_pop();
    test_overflow();
    test_full_pop();
    test_collide_clr();
    test_cap_en();
    test_drop_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
